// File: rtl/char_scanout_pkg.sv
// char_scanout_pkg
// Shared constants and types for the text-mode scanout stage.
//   SPACE_CHAR    : character code written by the clear-screen sequencer
//   COLS_DEF      : default number of text columns
//   ROWS_DEF      : default number of text rows
//   scan_state_t  : clear-screen sequencer states
package char_scanout_pkg;

    localparam logic [7:0] SPACE_CHAR = 8'h20;
    localparam int         COLS_DEF   = 80;
    localparam int         ROWS_DEF   = 30;

    typedef enum logic {
        CLEAR,
        IDLE
    } scan_state_t;

endpackage

// File: rtl/char_scanout_text.sv
// text_ram
// Single-clock character buffer with one write port and one synchronous
// read port. A read and a write to the same address in the same cycle
// return the old contents.
//   clk    : clock
//   rst    : synchronous active-high reset (read register only)
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : registered read data, RST_VAL after reset
module text_ram #(
    parameter int                DATA_W  = 8,
    parameter int                DEPTH   = 2400,
    parameter logic [DATA_W-1:0] RST_VAL = '0,
    localparam int               ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // The storage array is not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Non-blocking update of mem_q gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= RST_VAL;
        end else begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/char_scanout.sv
// char_scanout
// Text-mode scanout stage in front of the glyph ROM. Holds a COLS x ROWS
// character buffer written by a host port, turns each pixel coordinate into
// a glyph ROM lookup and registers the returned glyph bit as the video pixel.
// Sync and blanking are delayed to stay aligned (2 cycles for every output).
// A clear-screen sequencer fills the buffer with spaces after reset or on
// clear_req.
// Optional build macro CHAR_SCANOUT_CURSOR_EN adds a blinking block cursor
// (ports cursor_col/cursor_row, blink from a vsync frame counter).
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   x, y, display_on            : current pixel coordinate and visible flag
//   hsync_in, vsync_in          : syncs from the timing generator
//   wr_en/wr_col/wr_row/wr_char : host write port, wr_ready when accepted
//   clear_req                   : single-cycle clear-screen request
//   char_code/hpos/vpos         : glyph ROM address, char_pixel its response
//   pixel_out, hsync_out, vsync_out, display_on_out : aligned video outputs
module char_scanout
    import char_scanout_pkg::*;
#(
    parameter int  CHAR_HORZ_PX_SIZE = 8,
    parameter int  CHAR_VERT_PX_SIZE = 16,
    parameter int  COLS              = COLS_DEF,
    parameter int  ROWS              = ROWS_DEF,
    parameter int  X_W               = 10,
    parameter int  Y_W               = 10,
    localparam int CHAR_HORZ_PX_W    = $clog2(CHAR_HORZ_PX_SIZE),
    localparam int CHAR_VERT_PX_W    = $clog2(CHAR_VERT_PX_SIZE)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [X_W-1:0]            x,
    input  logic [Y_W-1:0]            y,
    input  logic                      display_on,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic                      wr_en,
    input  logic [6:0]                wr_col,
    input  logic [4:0]                wr_row,
    input  logic [7:0]                wr_char,
    output logic                      wr_ready,
    input  logic                      clear_req,
    output logic [7:0]                char_code,
    output logic [CHAR_HORZ_PX_W-1:0] char_hpos,
    output logic [CHAR_VERT_PX_W-1:0] char_vpos,
    input  logic                      char_pixel,
    output logic                      pixel_out,
    output logic                      hsync_out,
    output logic                      vsync_out,
    output logic                      display_on_out
`ifdef CHAR_SCANOUT_CURSOR_EN
   ,input  logic [6:0]                cursor_col,
    input  logic [4:0]                cursor_row
`endif
);

    localparam int CELLS  = COLS * ROWS;
    localparam int ADDR_W = $clog2(CELLS);
    localparam int COL_W  = X_W - CHAR_HORZ_PX_W;
    localparam int ROW_W  = Y_W - CHAR_VERT_PX_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

    scan_state_t       state_q;
    logic [ADDR_W-1:0] clr_addr_q;
    logic              wr_ready_q;

    logic [COL_W-1:0]  scan_col;
    logic [ROW_W-1:0]  scan_row;
    logic              in_area;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_in_range;
    logic [ADDR_W-1:0] host_addr;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [7:0]        ram_wdata;

    logic [CHAR_HORZ_PX_W-1:0] hpos_q;
    logic [CHAR_VERT_PX_W-1:0] vpos_q;
    logic de_q1, hs_q1, vs_q1, area_q1;
    logic de_q2, hs_q2, vs_q2, pix_q;
    logic glyph_bit;

    // Glyph sizes are powers of two, so the cell index is a bit slice.
    assign scan_col = x[X_W-1:CHAR_HORZ_PX_W];
    assign scan_row = y[Y_W-1:CHAR_VERT_PX_W];
    assign in_area  = (32'(scan_col) < COLS) && (32'(scan_row) < ROWS);
    assign rd_addr  = in_area ? ADDR_W'(32'(scan_row) * COLS + 32'(scan_col)) : LAST_ADDR;

    assign wr_in_range = (32'(wr_col) < COLS) && (32'(wr_row) < ROWS);
    assign host_addr   = ADDR_W'(32'(wr_row) * COLS + 32'(wr_col));

    // Clear owns the write port; host writes lose to a same-cycle clear_req.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = host_addr;
        ram_wdata = wr_char;
        if (state_q == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr_q;
            ram_wdata = SPACE_CHAR;
        end else if (wr_en && wr_in_range && !clear_req) begin
            ram_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
            wr_ready_q <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (clr_addr_q == LAST_ADDR) begin
                        state_q    <= IDLE;
                        wr_ready_q <= 1'b1;
                    end else begin
                        clr_addr_q <= clr_addr_q + ADDR_W'(1);
                    end
                end
                IDLE: begin
                    if (clear_req) begin
                        state_q    <= CLEAR;
                        clr_addr_q <= '0;
                        wr_ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= CLEAR;
                    clr_addr_q <= '0;
                    wr_ready_q <= 1'b0;
                end
            endcase
        end
    end

    text_ram #(
        .DATA_W  (8),
        .DEPTH   (CELLS),
        .RST_VAL (SPACE_CHAR)
    ) u_text_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (rd_addr),
        .rdata (char_code)
    );

`ifdef CHAR_SCANOUT_CURSOR_EN
    logic       vs_prev_q;
    logic [5:0] frame_q;
    logic       cur_hit_q1;

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_prev_q  <= 1'b0;
            frame_q    <= '0;
            cur_hit_q1 <= 1'b0;
        end else begin
            vs_prev_q <= vsync_in;
            if (vsync_in && !vs_prev_q) begin
                frame_q <= frame_q + 6'd1;
            end
            cur_hit_q1 <= in_area && (32'(scan_col) == 32'(cursor_col))
                                  && (32'(scan_row) == 32'(cursor_row));
        end
    end

    // Upper counter bit gives a 32-frame on / 32-frame off blink.
    assign glyph_bit = char_pixel ^ (cur_hit_q1 & frame_q[5]);
`else
    assign glyph_bit = char_pixel;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            hpos_q  <= '0;
            vpos_q  <= '0;
            de_q1   <= 1'b0;
            hs_q1   <= 1'b0;
            vs_q1   <= 1'b0;
            area_q1 <= 1'b0;
            de_q2   <= 1'b0;
            hs_q2   <= 1'b0;
            vs_q2   <= 1'b0;
            pix_q   <= 1'b0;
        end else begin
            hpos_q  <= x[CHAR_HORZ_PX_W-1:0];
            vpos_q  <= y[CHAR_VERT_PX_W-1:0];
            de_q1   <= display_on;
            hs_q1   <= hsync_in;
            vs_q1   <= vsync_in;
            area_q1 <= in_area;
            de_q2   <= de_q1;
            hs_q2   <= hs_q1;
            vs_q2   <= vs_q1;
            pix_q   <= glyph_bit & de_q1 & area_q1 & (state_q == IDLE);
        end
    end

    assign wr_ready       = wr_ready_q;
    assign char_hpos      = hpos_q;
    assign char_vpos      = vpos_q;
    assign pixel_out      = pix_q;
    assign hsync_out      = hs_q2;
    assign vsync_out      = vs_q2;
    assign display_on_out = de_q2;

endmodule
